player_action_ctrl: RTL and testbench
=====================================

PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 The block SHALL have parameter SMASH_FRAMES, default 8, giving the number of frames the smash stays active (legal range 1..255).
REQ-002 The block SHALL have parameter COOLDOWN_FRAMES, default 16, giving the number of frames after a smash before the next one is allowed (legal range 1..255).
REQ-003 The block SHALL have parameter JUMP_BUF_FRAMES, default 4, giving the number of frames a jump press stays pending while airborne (legal range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port frame_tick, input, 1 bit: one-clk pulse marking each game frame.
REQ-007 The block SHALL have ports op_move_left, op_move_right, op_jump and op_smash, input, 1 bit each: debounced level button states, 1 = pressed.
REQ-008 The block SHALL have port on_ground, input, 1 bit: player is grounded, driven by the physics block.
REQ-009 The block SHALL have port move_dir, output, 2 bits: 00 = none, 01 = right, 10 = left; the value 11 is never driven.
REQ-010 The block SHALL have port jump_pulse, output, 1 bit: one-clk jump command to physics.
REQ-011 The block SHALL have port smash_active, output, 1 bit: level output, high while a smash is in progress.
REQ-012 The block SHALL have port smash_ready, output, 1 bit: level output, high while a new smash is accepted.

Function
REQ-013 The block SHALL sample op_* and on_ground only in cycles where frame_tick=1; all other cycles leave the state unchanged.
REQ-014 All outputs SHALL be registered and SHALL update at the clk edge ending a frame_tick cycle, giving 1-cycle latency.
REQ-015 Rising edges SHALL be computed against the op_* values sampled at the previous frame_tick.
REQ-016 move_dir SHALL follow these rules:
- left only: 10.
- right only: 01.
- neither: 00.
- both held: the direction whose rising edge occurred at the later tick wins.
- both rising at the same tick: 00.
REQ-017 move_dir SHALL hold its value between ticks.
REQ-018 A jump rising edge at a tick SHALL load the jump buffer with JUMP_BUF_FRAMES, reloading any value already pending.
REQ-019 At each tick where the buffer is nonzero (including the tick that loaded it), the jump buffer SHALL behave as follows:
- on_ground=1: jump_pulse=1 for exactly one clk cycle and the buffer clears.
- on_ground=0: the buffer decrements; at 0 the request is dropped.
REQ-020 A held op_jump SHALL NOT retrigger a jump; a release and a new press are required.
REQ-021 The smash FSM SHALL have three states: IDLE, ACTIVE and COOLDOWN.
REQ-022 In IDLE, smash_ready=1 and smash_active=0; a smash rising edge at a tick SHALL move the FSM to ACTIVE.
REQ-023 ACTIVE SHALL hold smash_active=1 and smash_ready=0 for exactly SMASH_FRAMES ticks, then move to COOLDOWN.
REQ-024 COOLDOWN SHALL hold smash_active=0 and smash_ready=0 for exactly COOLDOWN_FRAMES ticks, then move to IDLE.
REQ-025 Smash edges arriving in ACTIVE or COOLDOWN SHALL be discarded, not queued; a held op_smash on return to IDLE SHALL NOT trigger a smash.
REQ-026 The jump logic and the smash FSM SHALL be independent; a jump is allowed during a smash.
REQ-027 Each counter SHALL be wide enough to hold its parameter maximum (8 bits at the legal range); no counter SHALL wrap.

Reset
REQ-028 rst_n=0 SHALL asynchronously force:
- move_dir=00, jump_pulse=0, smash_active=0, smash_ready=1.
- FSM to IDLE and all counters to 0.
- the jump buffer to 0 and all previous-sample registers to 0.
REQ-029 A button held while rst_n deasserts SHALL register as a rising edge at the first tick after reset.
REQ-030 Reset asserted in the middle of a smash or cooldown SHALL abort it with no residual state.

Configuration
REQ-031 The jump buffer SHALL be controlled by macro PLAYER_JUMP_BUFFER_EN.
REQ-032 With PLAYER_JUMP_BUFFER_EN defined, jump behaviour SHALL be as in REQ-018 and REQ-019.
REQ-033 Without PLAYER_JUMP_BUFFER_EN:
- jump_pulse SHALL fire only at the tick where the jump edge is detected and on_ground=1.
- a jump edge detected while airborne SHALL be discarded.
- JUMP_BUF_FRAMES SHALL be ignored and no buffer register SHALL exist.

Verification
REQ-034 The bench SHALL cover: op_move_left=1 at tick 1, then op_move_right=1 at tick 3 with both held -> move_dir=10 after tick 1 and 01 after tick 3; both released -> 00.
REQ-035 The bench SHALL cover, with the buffer enabled: jump edge at tick 0 with on_ground=0, on_ground=1 at tick 2 -> a single jump_pulse one cycle after tick 2; with on_ground=1 only at tick 5 -> no pulse.
REQ-036 The bench SHALL cover, with the buffer disabled: jump edge with on_ground=0 -> no pulse, even when on_ground rises the next tick.
REQ-037 The bench SHALL cover, at default parameters: smash press -> smash_active high for 8 ticks, then smash_ready low for 16 more ticks; a second press at tick 10 is ignored; smash_ready=1 after tick 24.
REQ-038 The bench SHALL cover: rst_n pulsed low mid-ACTIVE -> smash_active=0 and smash_ready=1 immediately, without waiting for a clk edge.
REQ-039 The bench SHALL cover: op_* toggled between ticks with frame_tick=0 -> no output change.

Source files
------------

// File: rtl/player_action_ctrl.sv
// Player input controller: frame-sampled move direction, jump command and smash FSM.
// Build option: define PLAYER_JUMP_BUFFER_EN to hold airborne jump presses for JUMP_BUF_FRAMES frames.
module player_action_ctrl #(
    parameter int SMASH_FRAMES    = 8,
    parameter int COOLDOWN_FRAMES = 16,
    parameter int JUMP_BUF_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       op_move_left,
    input  logic       op_move_right,
    input  logic       op_jump,
    input  logic       op_smash,
    input  logic       on_ground,
    output logic [1:0] move_dir,
    output logic       jump_pulse,
    output logic       smash_active,
    output logic       smash_ready
);

    localparam int CNT_W = 8;

    localparam logic [1:0] DIR_NONE  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    localparam logic [CNT_W-1:0] SMASH_LAST    = CNT_W'(SMASH_FRAMES - 1);
    localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

    if (SMASH_FRAMES < 1 || SMASH_FRAMES > 255) begin : g_badSmashFrames
        $error("SMASH_FRAMES must lie in 1..255");
    end
    if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 255) begin : g_badCooldownFrames
        $error("COOLDOWN_FRAMES must lie in 1..255");
    end
    if (JUMP_BUF_FRAMES < 1 || JUMP_BUF_FRAMES > 255) begin : g_badJumpBufFrames
        $error("JUMP_BUF_FRAMES must lie in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACTIVE   = 2'b01,
        COOLDOWN = 2'b10
    } smash_state_t;

    logic             r_prevLeft;
    logic             r_prevRight;
    logic             r_prevJump;
    logic             r_prevSmash;
    logic [1:0]       r_moveDir;
    logic             r_jumpPulse;
    smash_state_t     r_smashState;
    logic [CNT_W-1:0] r_smashCnt;
    logic             r_smashActive;
    logic             r_smashReady;

    logic             w_riseLeft;
    logic             w_riseRight;
    logic             w_riseJump;
    logic             w_riseSmash;
    logic [1:0]       w_nextDir;

    // Rising edges are relative to the buttons as seen at the previous frame tick.
    assign w_riseLeft  = op_move_left  & ~r_prevLeft;
    assign w_riseRight = op_move_right & ~r_prevRight;
    assign w_riseJump  = op_jump       & ~r_prevJump;
    assign w_riseSmash = op_smash      & ~r_prevSmash;

    // With both directions held, the most recent press wins; a simultaneous press cancels out.
    always_comb begin
        w_nextDir = r_moveDir;
        case ({op_move_left, op_move_right})
            2'b10:   w_nextDir = DIR_LEFT;
            2'b01:   w_nextDir = DIR_RIGHT;
            2'b00:   w_nextDir = DIR_NONE;
            default: begin
                if (w_riseLeft && w_riseRight) begin
                    w_nextDir = DIR_NONE;
                end else if (w_riseRight) begin
                    w_nextDir = DIR_RIGHT;
                end else if (w_riseLeft) begin
                    w_nextDir = DIR_LEFT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prevLeft  <= 1'b0;
            r_prevRight <= 1'b0;
            r_prevJump  <= 1'b0;
            r_prevSmash <= 1'b0;
            r_moveDir   <= DIR_NONE;
        end else if (frame_tick) begin
            r_prevLeft  <= op_move_left;
            r_prevRight <= op_move_right;
            r_prevJump  <= op_jump;
            r_prevSmash <= op_smash;
            r_moveDir   <= w_nextDir;
        end
    end

`ifdef PLAYER_JUMP_BUFFER_EN
    localparam logic [CNT_W-1:0] JUMP_LOAD = CNT_W'(JUMP_BUF_FRAMES);

    logic [CNT_W-1:0] r_jumpBuf;
    logic [CNT_W-1:0] w_jumpPending;

    // A fresh press reloads the buffer and is serviced within the same tick.
    assign w_jumpPending = w_riseJump ? JUMP_LOAD : r_jumpBuf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jumpBuf   <= '0;
            r_jumpPulse <= 1'b0;
        end else begin
            r_jumpPulse <= 1'b0;
            if (frame_tick && (w_jumpPending != '0)) begin
                if (on_ground) begin
                    r_jumpPulse <= 1'b1;
                    r_jumpBuf   <= '0;
                end else begin
                    r_jumpBuf   <= w_jumpPending - CNT_W'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jumpPulse <= 1'b0;
        end else begin
            r_jumpPulse <= frame_tick & w_riseJump & on_ground;
        end
    end
`endif

    // The counter holds the number of further ticks to spend in the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smashState  <= IDLE;
            r_smashCnt    <= '0;
            r_smashActive <= 1'b0;
            r_smashReady  <= 1'b1;
        end else if (frame_tick) begin
            case (r_smashState)
                IDLE: begin
                    if (w_riseSmash) begin
                        r_smashState  <= ACTIVE;
                        r_smashCnt    <= SMASH_LAST;
                        r_smashActive <= 1'b1;
                        r_smashReady  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (r_smashCnt == '0) begin
                        r_smashState  <= COOLDOWN;
                        r_smashCnt    <= COOLDOWN_LAST;
                        r_smashActive <= 1'b0;
                    end else begin
                        r_smashCnt    <= r_smashCnt - CNT_W'(1);
                    end
                end
                COOLDOWN: begin
                    if (r_smashCnt == '0) begin
                        r_smashState  <= IDLE;
                        r_smashReady  <= 1'b1;
                    end else begin
                        r_smashCnt    <= r_smashCnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_smashState  <= IDLE;
                    r_smashCnt    <= '0;
                    r_smashActive <= 1'b0;
                    r_smashReady  <= 1'b1;
                end
            endcase
        end
    end

    assign move_dir     = r_moveDir;
    assign jump_pulse   = r_jumpPulse;
    assign smash_active = r_smashActive;
    assign smash_ready  = r_smashReady;

endmodule

// File: tb/tb_player_action_ctrl.sv
// Scoreboard bench for player_action_ctrl: a frame-level reference model queues expected outputs per tick.
// Honours PLAYER_JUMP_BUFFER_EN to pick the matching jump model and directed scenarios.
module tb_player_action_ctrl;

    localparam int SF = 8;
    localparam int CF = 16;
    localparam int JB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       op_move_left = 1'b0;
    logic       op_move_right = 1'b0;
    logic       op_jump = 1'b0;
    logic       op_smash = 1'b0;
    logic       on_ground = 1'b0;
    logic [1:0] move_dir;
    logic       jump_pulse;
    logic       smash_active;
    logic       smash_ready;

    typedef struct packed {
        logic [1:0] dir;
        logic       jump;
        logic       active;
        logic       ready;
    } exp_t;

    localparam exp_t RESET_EXP = '{dir: 2'b00, jump: 1'b0, active: 1'b0, ready: 1'b1};

    exp_t expQ[$];
    exp_t lastExp = RESET_EXP;
    int   checks = 0;
    int   passes = 0;

    // Reference model state, expressed in frame numbers rather than counters.
    int   tickNum = 0;
    logic mPrevL, mPrevR, mPrevJ, mPrevS;
    int   lastRiseL, lastRiseR;
    logic jumpPending;
    int   jumpDeadline;
    int   smashStart;

    player_action_ctrl #(
        .SMASH_FRAMES   (SF),
        .COOLDOWN_FRAMES(CF),
        .JUMP_BUF_FRAMES(JB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .op_move_left (op_move_left),
        .op_move_right(op_move_right),
        .op_jump      (op_jump),
        .op_smash     (op_smash),
        .on_ground    (on_ground),
        .move_dir     (move_dir),
        .jump_pulse   (jump_pulse),
        .smash_active (smash_active),
        .smash_ready  (smash_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input exp_t e);
        exp_t act;
        act = '{dir: move_dir, jump: jump_pulse, active: smash_active, ready: smash_ready};
        checks++;
        if (act === e) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s @%0t: got dir=%b jump=%b active=%b ready=%b, expected dir=%b jump=%b active=%b ready=%b",
                     name, $time, act.dir, act.jump, act.active, act.ready,
                     e.dir, e.jump, e.active, e.ready);
        end
    endtask

    task automatic resetModel();
        mPrevL       = 1'b0;
        mPrevR       = 1'b0;
        mPrevJ       = 1'b0;
        mPrevS       = 1'b0;
        lastRiseL    = -1;
        lastRiseR    = -1;
        jumpPending  = 1'b0;
        jumpDeadline = 0;
        smashStart   = -1;
    endtask

    task automatic modelTick(input logic l, input logic r, input logic j, input logic s,
                             input logic g, output exp_t e);
        logic riseL, riseR, riseJ, riseS;
        int   rel;
        riseL = l & ~mPrevL;
        riseR = r & ~mPrevR;
        riseJ = j & ~mPrevJ;
        riseS = s & ~mPrevS;
        if (riseL) lastRiseL = tickNum;
        if (riseR) lastRiseR = tickNum;

        if (l && !r)                    e.dir = 2'b10;
        else if (r && !l)               e.dir = 2'b01;
        else if (!l && !r)              e.dir = 2'b00;
        else if (lastRiseL == lastRiseR) e.dir = 2'b00;
        else                            e.dir = (lastRiseL > lastRiseR) ? 2'b10 : 2'b01;

`ifdef PLAYER_JUMP_BUFFER_EN
        if (riseJ) begin
            jumpPending  = 1'b1;
            jumpDeadline = tickNum + JB - 1;
        end
        e.jump = 1'b0;
        if (jumpPending) begin
            if (tickNum > jumpDeadline) begin
                jumpPending = 1'b0;
            end else if (g) begin
                e.jump      = 1'b1;
                jumpPending = 1'b0;
            end
        end
`else
        e.jump = riseJ & g;
`endif

        if (riseS && (smashStart < 0 || tickNum - smashStart > SF + CF)) smashStart = tickNum;
        if (smashStart < 0) begin
            e.active = 1'b0;
            e.ready  = 1'b1;
        end else begin
            rel      = tickNum - smashStart;
            e.active = (rel < SF);
            e.ready  = (rel >= SF + CF);
        end

        mPrevL = l;
        mPrevR = r;
        mPrevJ = j;
        mPrevS = s;
        tickNum++;
    endtask

    // One frame: present buttons with frame_tick for one clk, then idle cycles with scrambled buttons.
    task automatic applyStimulus(input logic l, input logic r, input logic j, input logic s,
                                 input logic g, input int gap);
        exp_t e;
        @(negedge clk);
        op_move_left  = l;
        op_move_right = r;
        op_jump       = j;
        op_smash      = s;
        on_ground     = g;
        frame_tick    = 1'b1;
        modelTick(l, r, j, s, g, e);
        expQ.push_back(e);
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            op_move_left  = 1'($urandom);
            op_move_right = 1'($urandom);
            op_jump       = 1'($urandom);
            op_smash      = 1'($urandom);
            on_ground     = 1'($urandom);
        end
    endtask

    // Monitor: after a tick edge pop the next expectation, otherwise outputs must hold (pulse cleared).
    initial begin
        logic sawTick, wasRst;
        exp_t idleExp;
        forever begin
            @(posedge clk);
            sawTick = frame_tick;
            wasRst  = rst_n;
            #1;
            if (!rst_n || !wasRst) continue;
            if (sawTick) begin
                if (expQ.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL scoreboard_underflow @%0t: got empty queue, expected an entry", $time);
                end else begin
                    lastExp = expQ.pop_front();
                    checkOutput("tick", lastExp);
                end
            end else begin
                idleExp      = lastExp;
                idleExp.jump = 1'b0;
                checkOutput("between_ticks", idleExp);
            end
        end
    end

    initial begin
        resetModel();
        repeat (2) @(negedge clk);
        checkOutput("reset_state", RESET_EXP);
        rst_n = 1'b1;

        // Direction: left at tick 1, right added at tick 3, both released; then a simultaneous press.
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 0, 1, 2);
        applyStimulus(1, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 3);
        applyStimulus(1, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

`ifdef PLAYER_JUMP_BUFFER_EN
        // Airborne press serviced on landing two frames later, then one that expires before landing.
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
`else
        // Airborne press is dropped even when landing next frame with the button still held.
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
`endif
        applyStimulus(0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Full smash cycle with a rejected re-press at frame 10 and a held button at return to idle.
        applyStimulus(0, 0, 0, 1, 1, 0);
        for (int i = 1; i < 30; i++) begin
            applyStimulus(0, 0, (i == 4), (i >= 10), 1, (i % 3));
        end
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);

        // Asynchronous abort mid-smash, with left held across reset release.
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", RESET_EXP);
        resetModel();
        lastExp = RESET_EXP;
        op_smash     = 1'b0;
        op_move_left = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Randomized frames with varying gaps.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0),
                          $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
